// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin walker over a (core, ctx, seq) thread space.
// A single pointer steps through every thread position; the first enabled,
// non-busy thread it lands on is offered until the consumer accepts it. The
// accepted thread is then busy until a matching done strobe arrives.
// ORDER selects the traversal: 0 = core fastest, then ctx, then seq;
// 1 = ctx fastest, then core, then seq.
// Optional feature: define THREAD_SCHEDULER_WRAP_CNT_EN to count completed
// traversals on wrap_cnt_o. When it is undefined, wrap_cnt_o is tied to 0.
module thread_scheduler #(
  parameter int N_CORES = 4,
  parameter int N_CTX   = 2,
  parameter int N_SEQ   = 2,
  parameter int ORDER   = 0,
  localparam int CW        = (N_CORES > 1) ? $clog2(N_CORES) : 1,
  localparam int XW        = (N_CTX > 1)   ? $clog2(N_CTX)   : 1,
  localparam int SW        = (N_SEQ > 1)   ? $clog2(N_SEQ)   : 1,
  localparam int TW        = CW + XW + SW,
  localparam int N_THREADS = N_CORES * N_CTX * N_SEQ
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_THREADS-1:0] thread_en_i,
  input  logic                 done_i,
  input  logic [TW-1:0]        done_num_i,
  output logic                 out_valid_o,
  input  logic                 out_rd_i,
  output logic [TW-1:0]        out_thread_num_o,
  output logic                 all_idle_o,
  output logic [15:0]          wrap_cnt_o
);

  localparam int LW = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(N_CORES - 1);
  localparam logic [XW-1:0] XMAX = XW'(N_CTX - 1);
  localparam logic [SW-1:0] SMAX = SW'(N_SEQ - 1);

  typedef enum logic {SCAN = 1'b0, OFFER = 1'b1} state_t;

  state_t               state_q;
  logic [CW-1:0]        core_q, core_d;
  logic [XW-1:0]        ctx_q, ctx_d;
  logic [SW-1:0]        seq_q, seq_d;
  logic [N_THREADS-1:0] busy_q;
  logic                 out_valid_q;
  logic [TW-1:0]        out_num_q;

  logic [LW-1:0]        cur_lin;
  logic                 eligible;
  logic                 accept;
  logic                 step;

  logic [CW-1:0]        dn_core;
  logic [XW-1:0]        dn_ctx;
  logic [SW-1:0]        dn_seq;
  logic                 dn_ok;
  logic [LW-1:0]        dn_lin;
  logic                 dn_hit;

  // Linear index of the pointer; the pointer never holds an unused encoding.
  assign cur_lin  = LW'(int'(core_q) * N_CTX * N_SEQ + int'(ctx_q) * N_SEQ + int'(seq_q));
  assign eligible = thread_en_i[cur_lin] & ~busy_q[cur_lin];
  assign accept   = (state_q == OFFER) & out_rd_i;
  // The pointer moves while scanning past ineligible slots and after an accept.
  assign step     = ((state_q == SCAN) & ~eligible) | accept;

  // done_num is only trusted when every field names a real core/ctx/seq.
  assign dn_core = done_num_i[TW-1 -: CW];
  assign dn_ctx  = done_num_i[SW +: XW];
  assign dn_seq  = done_num_i[SW-1:0];
  assign dn_ok   = (int'(dn_core) < N_CORES) && (int'(dn_ctx) < N_CTX) && (int'(dn_seq) < N_SEQ);
  assign dn_lin  = LW'(int'(dn_core) * N_CTX * N_SEQ + int'(dn_ctx) * N_SEQ + int'(dn_seq));
  assign dn_hit  = done_i & dn_ok & busy_q[dn_lin];

  // Next pointer position: odometer over the three fields in ORDER's nesting.
  always_comb begin
    core_d = core_q;
    ctx_d  = ctx_q;
    seq_d  = seq_q;
    if (ORDER == 0) begin
      if (core_q != CMAX) core_d = core_q + 1'b1;
      else begin
        core_d = '0;
        if (ctx_q != XMAX) ctx_d = ctx_q + 1'b1;
        else begin
          ctx_d = '0;
          if (seq_q != SMAX) seq_d = seq_q + 1'b1;
          else               seq_d = '0;
        end
      end
    end else begin
      if (ctx_q != XMAX) ctx_d = ctx_q + 1'b1;
      else begin
        ctx_d = '0;
        if (core_q != CMAX) core_d = core_q + 1'b1;
        else begin
          core_d = '0;
          if (seq_q != SMAX) seq_d = seq_q + 1'b1;
          else               seq_d = '0;
        end
      end
    end
  end

  // Scan/offer FSM with registered offer outputs and the traversal pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= SCAN;
      core_q      <= '0;
      ctx_q       <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      out_num_q   <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (eligible) begin
            state_q     <= OFFER;
            out_valid_q <= 1'b1;
            out_num_q   <= {core_q, ctx_q, seq_q};
          end
        end
        OFFER: begin
          // Offer is held regardless of thread_en until the consumer takes it.
          if (out_rd_i) begin
            state_q     <= SCAN;
            out_valid_q <= 1'b0;
          end
        end
      endcase
      if (step) begin
        core_q <= core_d;
        ctx_q  <= ctx_d;
        seq_q  <= seq_d;
      end
    end
  end

  // Busy tracking: done clears, accept sets; on different threads both apply.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else begin
      if (dn_hit) busy_q[dn_lin]  <= 1'b0;
      if (accept) busy_q[cur_lin] <= 1'b1;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_thread_num_o = out_num_q;
  assign all_idle_o       = ~|busy_q;

`ifdef THREAD_SCHEDULER_WRAP_CNT_EN
  logic        at_last;
  logic [15:0] wrap_q;

  assign at_last = (core_q == CMAX) && (ctx_q == XMAX) && (seq_q == SMAX);

  // Count every step that takes the pointer from the last slot back to origin.
  always_ff @(posedge clk_i) begin
    if (reset_i)             wrap_q <= '0;
    else if (step & at_last) wrap_q <= wrap_q + 16'd1;
  end

  assign wrap_cnt_o = wrap_q;
`else
  assign wrap_cnt_o = '0;
`endif

endmodule
